fetch_redirect_stage: RTL and testbench
=======================================

Name: fetch_redirect_stage

Overview:
- Instruction-fetch stage plus next-PC/redirect resolution for the pipelined core.
- Holds the PC, drives the instruction-memory address, and registers the fetched word into the fetch/decode (F/D) pipeline register that feeds the control unit.
- Consumes the EX-stage copies of the control unit's branch[2:0] and Jump[1:0] encodings and resolves taken branches and jumps.
- Issues flushes of the younger stages on a redirect.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and operand buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_f  in  1  hazard unit request to hold PC and F/D register.
- imem_addr  out  DATA_WIDTH  instruction-memory address; equals pc_f.
- imem_rdata  in  DATA_WIDTH  instruction word; combinational read of imem_addr.
- valid_e  in  1  EX-stage instruction is valid.
- branch_e  in  3  EX branch code: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU.
- jump_e  in  2  EX jump code: 0x none, 10 JAL, 11 JALR.
- pc_e  in  DATA_WIDTH  PC of the EX instruction.
- imm_e  in  DATA_WIDTH  sign-extended immediate of the EX instruction.
- rd1_e, rd2_e  in  DATA_WIDTH  forwarded source operands.
- instr_d  out  DATA_WIDTH  F/D instruction, to the control unit.
- pc_d  out  DATA_WIDTH  F/D PC.
- pcplus4_d  out  DATA_WIDTH  F/D PC+4, link value for JAL/JALR.
- valid_d  out  1  F/D entry holds a real instruction.
- flush_e  out  1  combinational; kill the instruction entering EX next cycle.
- pc_f  out  DATA_WIDTH  current fetch PC.

Behaviour:
- Reset (rst high at posedge):
  - pc_f = RESET_PC.
  - instr_d = NOP_INSTR, pc_d = 0, pcplus4_d = 0, valid_d = 0.
  - Redirect counter = 0.
  - flush_e reads 0 while rst is high.
  - Reset mid-redirect or mid-stall discards both; the next fetch is RESET_PC.
- Branch condition, evaluated only when valid_e = 1:
  - BEQ: rd1_e == rd2_e. BNE: rd1_e != rd2_e.
  - BLT/BGE: signed less-than / greater-or-equal.
  - BLTU/BGEU: unsigned less-than / greater-or-equal.
  - Codes 000 and 111: not a branch.
- Targets (all arithmetic modulo 2^DATA_WIDTH; wrap-around is silent):
  - Branch and JAL: pc_e + imm_e.
  - JALR: (rd1_e + imm_e) with bit 0 cleared.
- taken = valid_e & (branch condition true | jump_e[1]). jump_e[1] takes precedence over branch_e if both are set.
- flush_e = taken.
- Priority on each posedge, highest first: rst, taken, stall_f, normal.
  - taken:
    - pc_f <= target.
    - F/D <= NOP_INSTR, valid_d <= 0, pc_d and pcplus4_d hold.
    - This applies even if stall_f = 1; the redirect overrides the stall.
  - stall_f (not taken): pc_f and all F/D outputs hold.
  - normal:
    - pc_f <= pc_f + 4.
    - instr_d <= imem_rdata, pc_d <= pc_f, pcplus4_d <= pc_f + 4, valid_d <= 1.
- Latency:
  - Fetched word appears on instr_d one cycle after pc_f presents it.
  - Redirect: target is on pc_f in the cycle after taken, and its instruction is on instr_d one cycle later.
  - Cost is 2 bubbles: one in F/D, and one in EX via flush_e.
- Not-taken or invalid EX instructions never redirect, whatever the branch_e/jump_e values.
- Target bit 1 set (misaligned): fetched as-is; no trap in this block.
- Back-to-back redirects in consecutive cycles are impossible, because the flushed slot has valid_e = 0. The design must still honour each taken cycle independently.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports redirect_cnt (32) and fetch_cnt (32).
  - redirect_cnt increments on each posedge with taken = 1 and rst = 0.
  - fetch_cnt increments on each normal-advance posedge.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset, then 3 free-running cycles with imem returning 0x00500093, 0x00100113, 0x002081B3.
   -> pc_f reads 0, 4, 8, 0xC.
   -> instr_d reads NOP, 0x00500093, 0x00100113, 0x002081B3.
   -> valid_d reads 0, 1, 1, 1.
2. valid_e=1, branch_e=001, rd1_e=rd2_e=7, pc_e=0x10, imm_e=0xFFFFFFF8.
   -> flush_e=1 same cycle; next pc_f=0x08; instr_d=NOP, valid_d=0.
   -> Repeat with rd2_e=8: no redirect, pc_f advances by 4.
3. BLT vs BLTU with rd1_e=0xFFFFFFFF, rd2_e=1.
   -> BLT taken, BLTU not taken.
   -> BGEU taken, BGE not taken.
4. jump_e=11, rd1_e=0x101, imm_e=4, stall_f=1 in the same cycle.
   -> pc_f=0x104 (bit 0 cleared), redirect overrides stall.
   -> jump_e=10, pc_e=0xFFFFFFFC, imm_e=8: pc_f=0x4 (wrap).
5. stall_f held 3 cycles at pc_f=0x20.
   -> pc_f, instr_d, pc_d constant.
   -> On release, pc_f=0x24 and instr_d=imem_rdata@0x20.
6. rst asserted during a taken cycle, then released.
   -> pc_f=RESET_PC, valid_d=0.
   -> With FETCH_PERF_CNT_EN: redirect_cnt=0. After two taken branches, redirect_cnt=2.

Source files
------------

// File: rtl/fetch_redirect_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_stage
//  Description : Instruction-fetch stage with next-PC / redirect resolution.
//                Holds the fetch PC and drives the instruction-memory address.
//                Registers the fetched word into the F/D pipeline register.
//                Resolves EX-stage branches and jumps. On a redirect it
//                squashes F/D and raises flush_e for the instruction that is
//                about to enter EX.
//  Option      : `define FETCH_PERF_CNT_EN adds the redirect_cnt and
//                fetch_cnt performance counters and their output ports.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock (rising edge), synchronous active-high reset
//    stall_f           hold PC and F/D register (hazard unit)
//    imem_addr         instruction-memory address (= pc_f)
//    imem_rdata        combinational instruction word at imem_addr
//    valid_e           EX-stage instruction is valid
//    branch_e, jump_e  EX-stage branch / jump encodings from the control unit
//    pc_e, imm_e       EX-stage PC and sign-extended immediate
//    rd1_e, rd2_e      forwarded EX-stage source operands
//    instr_d, pc_d,    F/D register contents
//    pcplus4_d,
//    valid_d
//    flush_e           combinational kill of the instruction entering EX
//    pc_f              current fetch PC
//    redirect_cnt,     (FETCH_PERF_CNT_EN only) taken redirects and normal
//    fetch_cnt         fetch advances since reset
// ============================================================================
module fetch_redirect_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  valid_e,
  input  logic [2:0]            branch_e,
  input  logic [1:0]            jump_e,
  input  logic [DATA_WIDTH-1:0] pc_e,
  input  logic [DATA_WIDTH-1:0] imm_e,
  input  logic [DATA_WIDTH-1:0] rd1_e,
  input  logic [DATA_WIDTH-1:0] rd2_e,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pcplus4_d,
  output logic                  valid_d,
  output logic                  flush_e,
  output logic [DATA_WIDTH-1:0] pc_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           redirect_cnt,
  output logic [31:0]           fetch_cnt
`else
`endif
);

  localparam logic [DATA_WIDTH-1:0] C_FOUR       = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] C_ALIGN_MASK = ~DATA_WIDTH'(1);

  localparam logic [2:0] C_BR_BEQ  = 3'b001;
  localparam logic [2:0] C_BR_BNE  = 3'b010;
  localparam logic [2:0] C_BR_BLT  = 3'b011;
  localparam logic [2:0] C_BR_BGE  = 3'b100;
  localparam logic [2:0] C_BR_BLTU = 3'b101;
  localparam logic [2:0] C_BR_BGEU = 3'b110;

  logic [DATA_WIDTH-1:0] pc_f_q,      pc_f_d;
  logic [DATA_WIDTH-1:0] instr_d_q,   instr_d_d;
  logic [DATA_WIDTH-1:0] pc_d_q,      pc_d_d;
  logic [DATA_WIDTH-1:0] pcplus4_d_q, pcplus4_d_d;
  logic                  valid_d_q,   valid_d_d;

  logic                  br_cond;
  logic                  taken;
  logic                  advance;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] pc_f_plus4;

  // Branch condition; codes 000 and 111 never branch.
  always_comb begin
    br_cond = 1'b0;
    case (branch_e)
      C_BR_BEQ:  br_cond = (rd1_e == rd2_e);
      C_BR_BNE:  br_cond = (rd1_e != rd2_e);
      C_BR_BLT:  br_cond = ($signed(rd1_e) <  $signed(rd2_e));
      C_BR_BGE:  br_cond = ($signed(rd1_e) >= $signed(rd2_e));
      C_BR_BLTU: br_cond = (rd1_e <  rd2_e);
      C_BR_BGEU: br_cond = (rd1_e >= rd2_e);
      default:   br_cond = 1'b0;
    endcase
  end

  // A jump wins over any branch code presented alongside it.
  assign taken   = valid_e & (jump_e[1] | br_cond);
  assign advance = ~taken & ~stall_f;

  // JALR aligns to a halfword by clearing bit 0; everything else is PC-relative.
  always_comb begin
    target = pc_e + imm_e;
    if (jump_e == 2'b11) begin
      target = (rd1_e + imm_e) & C_ALIGN_MASK;
    end
  end

  assign pc_f_plus4 = pc_f_q + C_FOUR;

  // Next state: a redirect overrides a stall. On a redirect pc_d/pcplus4_d keep
  // their values; only the instruction and valid bit are squashed.
  always_comb begin
    pc_f_d      = pc_f_q;
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;
    if (taken) begin
      pc_f_d    = target;
      instr_d_d = NOP_INSTR;
      valid_d_d = 1'b0;
    end else if (!stall_f) begin
      pc_f_d      = pc_f_plus4;
      instr_d_d   = imem_rdata;
      pc_d_d      = pc_f_q;
      pcplus4_d_d = pc_f_plus4;
      valid_d_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q      <= RESET_PC;
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= '0;
      pcplus4_d_q <= '0;
      valid_d_q   <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] fetch_cnt_q,    fetch_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q + {31'd0, taken};
    fetch_cnt_d    = fetch_cnt_q    + {31'd0, advance};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      fetch_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      fetch_cnt_q    <= fetch_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign fetch_cnt    = fetch_cnt_q;
`else
  // Without the counters, advance only documents the normal-advance case.
  logic unused_advance;
  assign unused_advance = advance;
`endif

  // Reset takes priority over a redirect, so no flush is reported during reset.
  assign flush_e   = taken & ~rst;
  assign imem_addr = pc_f_q;
  assign pc_f      = pc_f_q;
  assign instr_d   = instr_d_q;
  assign pc_d      = pc_d_q;
  assign pcplus4_d = pcplus4_d_q;
  assign valid_d   = valid_d_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_redirect_stage
//  Description : Directed scoreboard bench for fetch_redirect_stage. The driver
//                applies inputs on the falling edge and queues the expected
//                observation for that cycle. The monitor pops the queue and
//                compares the sampled DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_stage;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid_e = 1'b0;
  logic [2:0]  branch_e = 3'b000;
  logic [1:0]  jump_e = 2'b00;
  logic [31:0] pc_e = '0, imm_e = '0, rd1_e = '0, rd2_e = '0;
  logic [31:0] instr_d, pc_d, pcplus4_d, pc_f;
  logic        valid_d, flush_e;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt, fetch_cnt;
`endif

  always #5 clk = ~clk;

  // Instruction memory model: three fixed words, otherwise a tagged address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h0020_81B3;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction
  assign imem_rdata = imem(imem_addr);

  fetch_redirect_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .valid_e(valid_e), .branch_e(branch_e), .jump_e(jump_e),
    .pc_e(pc_e), .imm_e(imm_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .flush_e(flush_e), .pc_f(pc_f)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_cnt(redirect_cnt), .fetch_cnt(fetch_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4;
    logic        vd;
    logic        fl;
    logic        ck;
    logic [31:0] rc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   smp      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (sample %0d): got %h expected %h", nm, smp, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, after the falling-edge inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_f",      pc_f,              e.pc);
        chk("imem_addr", imem_addr,         e.pc);
        chk("instr_d",   instr_d,           e.instr);
        chk("pc_d",      pc_d,              e.pcd);
        chk("pcplus4_d", pcplus4_d,         e.p4);
        chk("valid_d",   {31'd0, valid_d},  {31'd0, e.vd});
        chk("flush_e",   {31'd0, flush_e},  {31'd0, e.fl});
`ifdef FETCH_PERF_CNT_EN
        if (e.ck) begin
          chk("redirect_cnt", redirect_cnt, e.rc);
          chk("fetch_cnt",    fetch_cnt,    e.fc);
        end
`endif
        smp++;
      end
    end
  end

  task automatic drv(input logic r, input logic st, input logic v,
                     input logic [2:0] br, input logic [1:0] jp,
                     input logic [31:0] pce, input logic [31:0] imm,
                     input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; stall_f = st; valid_e = v; branch_e = br; jump_e = jp;
    pc_e = pce; imm_e = imm; rd1_e = a; rd2_e = b;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic ex(input logic [31:0] pc, input logic [31:0] instr,
                    input logic [31:0] pcd, input logic [31:0] p4,
                    input logic vd, input logic fl,
                    input logic ck, input logic [31:0] rc, input logic [31:0] fc);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pcd = pcd; e.p4 = p4;
    e.vd = vd; e.fl = fl; e.ck = ck; e.rc = rc; e.fc = fc;
    q.push_back(e);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; a JAL presented during reset must not flush.
    drv(1, 0, 1, 3'b000, 2'b10, 32'h40, 32'h0, 32'h0, 32'h0);
    ex(32'h0, C_NOP, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    // Free-running fetch.
    idle(); ex(32'h0, C_NOP,         32'h0, 32'h0, 0, 0, 0, 0, 0);
    idle(); ex(32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 0, 0, 0);
    idle(); ex(32'h8, 32'h0010_0113, 32'h4, 32'h8, 1, 0, 0, 0, 0);
    // BEQ taken backwards: 0x10 + (-8) = 0x08.
    drv(0, 0, 1, 3'b001, 2'b00, 32'h10, 32'hFFFF_FFF8, 32'd7, 32'd7);
    ex(32'hC, 32'h0020_81B3, 32'h8, 32'hC, 1, 1, 0, 0, 0);
    idle(); ex(32'h8, C_NOP,         32'h8, 32'hC, 0, 0, 0, 0, 0);
    // BEQ not taken.
    drv(0, 0, 1, 3'b001, 2'b00, 32'h10, 32'hFFFF_FFF8, 32'd7, 32'd8);
    ex(32'hC, 32'h0020_81B3, 32'h8, 32'hC, 1, 0, 0, 0, 0);
    // Signed vs unsigned compares with -1 vs 1.
    drv(0, 0, 1, 3'b011, 2'b00, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);   // BLT taken
    ex(32'h10, 32'hC000_000C, 32'hC, 32'h10, 1, 1, 0, 0, 0);
    drv(0, 0, 1, 3'b101, 2'b00, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);   // BLTU not taken
    ex(32'h120, C_NOP, 32'hC, 32'h10, 0, 0, 0, 0, 0);
    drv(0, 0, 1, 3'b110, 2'b00, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);   // BGEU taken
    ex(32'h124, 32'hC000_0120, 32'h120, 32'h124, 1, 1, 0, 0, 0);
    drv(0, 0, 1, 3'b100, 2'b00, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);   // BGE not taken
    ex(32'h210, C_NOP, 32'h120, 32'h124, 0, 0, 0, 0, 0);
    // JALR with stall: 0x101 + 4 = 0x105, bit 0 cleared -> 0x104.
    drv(0, 1, 1, 3'b000, 2'b11, 32'h300, 32'h4, 32'h101, 32'h0);
    ex(32'h214, 32'hC000_0210, 32'h210, 32'h214, 1, 1, 0, 0, 0);
    // JAL wrapping: 0xFFFFFFFC + 8 = 0x4 (back-to-back redirect).
    drv(0, 0, 1, 3'b000, 2'b10, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
    ex(32'h104, C_NOP, 32'h210, 32'h214, 0, 1, 0, 0, 0);
    // Invalid EX with jump and true branch: no redirect.
    drv(0, 0, 0, 3'b001, 2'b11, 32'h0, 32'h0, 32'h5, 32'h5);
    ex(32'h4, C_NOP, 32'h210, 32'h214, 0, 0, 0, 0, 0);
    // Valid but jump 01 and branch 111: no redirect.
    drv(0, 0, 1, 3'b111, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0);
    ex(32'h8, 32'h0010_0113, 32'h4, 32'h8, 1, 0, 0, 0, 0);
    // JAL to 0x1C, then advance to 0x20 and stall three cycles.
    drv(0, 0, 1, 3'b000, 2'b10, 32'h10, 32'hC, 32'h0, 32'h0);
    ex(32'hC, 32'h0020_81B3, 32'h8, 32'hC, 1, 1, 0, 0, 0);
    idle(); ex(32'h1C, C_NOP, 32'h8, 32'hC, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      ex(32'h20, 32'hC000_001C, 32'h1C, 32'h20, 1, 0, 0, 0, 0);
    end
    idle(); ex(32'h20, 32'hC000_001C, 32'h1C, 32'h20, 1, 0, 0, 0, 0);
    // Reset during a taken cycle.
    drv(1, 0, 1, 3'b000, 2'b10, 32'h500, 32'h0, 32'h0, 32'h0);
    ex(32'h24, 32'hC000_0020, 32'h20, 32'h24, 1, 0, 0, 0, 0);
    idle(); ex(32'h0, C_NOP, 32'h0, 32'h0, 0, 0, 1, 0, 0);
    // Two taken redirects for the counters.
    drv(0, 0, 1, 3'b001, 2'b00, 32'h40, 32'h0, 32'h3, 32'h3);
    ex(32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 1, 1, 0, 1);
    idle(); ex(32'h40, C_NOP, 32'h0, 32'h4, 0, 0, 1, 1, 1);
    drv(0, 0, 1, 3'b000, 2'b10, 32'h80, 32'h0, 32'h0, 32'h0);
    ex(32'h44, 32'hC000_0040, 32'h40, 32'h44, 1, 1, 1, 1, 2);
    idle(); ex(32'h80, C_NOP, 32'h40, 32'h44, 0, 0, 1, 2, 2);

    @(negedge clk);
    #5;
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
